// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU datapath pipeline-stage registers:
// state encoding, default width and per-stage reset words.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Bubble words loaded on reset/flush: a NOP keeps the IR stage harmless.
  localparam logic [31:0] RV32_NOP   = 32'h0000_0013;
  localparam logic [15:0] ZERO_WORD16 = 16'h0000;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: data word plus valid flag, with
// load, clear-to-reset-value and drop (valid off, data held).
module pipe_slot #(
  parameter int                 WIDTH       = pipe_pkg::DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= RESET_VALUE;
      valid <= 1'b0;
    end else if (clear) begin
      data  <= RESET_VALUE;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and
// optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_e           state, next_state;
  logic             it, ot;
  logic             head_load, head_from_skid, head_drop;
  logic             skid_load, skid_drop;
  logic [WIDTH-1:0] head_in, skid_data;
  logic             skid_valid;

  assign it = in_valid & in_ready;
  assign ot = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    next_state     = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    head_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    case (state)
      ST_EMPTY: if (it) begin
        next_state = ST_ONE;
        head_load  = 1'b1;
      end
      ST_ONE: begin
        if (it && ot) begin
          head_load = 1'b1;
        end else if (it && SKID) begin
          next_state = ST_TWO;
          skid_load  = 1'b1;
        end else if (ot) begin
          next_state = ST_EMPTY;
          head_drop  = 1'b1;
        end
      end
      ST_TWO: if (ot) begin
        next_state     = ST_ONE;
        head_load      = 1'b1;
        head_from_skid = 1'b1;
        skid_drop      = 1'b1;
      end
      default: next_state = ST_EMPTY;
    endcase
    // Flush wins: any accepted input word is dropped, both slots empty.
    if (flush) begin
      next_state = ST_EMPTY;
      head_load  = 1'b0;
      head_drop  = 1'b0;
      skid_load  = 1'b0;
      skid_drop  = 1'b0;
    end
  end

  assign head_in = head_from_skid ? skid_data : in_data;

  pipe_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_head (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (head_load),
    .drop      (head_drop),
    .load_data (head_in),
    .data      (out_data),
    .valid     (out_valid)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q;

      pipe_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (skid_load),
        .drop      (skid_drop),
        .load_data (in_data),
        .data      (skid_data),
        .valid     (skid_valid)
      );

      // Registered ready: no combinational path from out_ready upstream.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= (next_state != ST_TWO);
      end
      assign in_ready = in_ready_q;
    end else begin : g_single
      assign skid_data  = '0;
      assign skid_valid = 1'b0;
      assign in_ready   = !out_valid | out_ready;
    end
  endgenerate

  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg, exercising a SKID=1 and a SKID=0
// instance side by side against a FIFO reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int             W  = 16;
  localparam logic [W-1:0]   RV = ZERO_WORD16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         flush1, iv1, ir1, ov1, or1;
  logic [W-1:0] d1, q1;
  logic [1:0]   occ1;
  logic         flush0, iv0, ir0, ov0, or0;
  logic [W-1:0] d0, q0;
  logic [1:0]   occ0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(q1), .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .SKID(1'b0)) dut_single (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(iv0), .in_ready(ir0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(q0), .occupancy(occ0)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] sb [2][$];
  logic [W-1:0] last [2];
  int           sent [2];
  bit           acc1, acc0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare one DUT against the model, then advance the model across the edge.
  task automatic score(input int k, input logic iv, input logic ir, input logic fl,
                       input logic ordy, input logic ov, input logic [W-1:0] din,
                       input logic [W-1:0] dout, input logic [1:0] occ, output bit acc);
    string pfx;
    logic  exp_ir, exp_ov;
    pfx    = (k == 1) ? "skid1" : "skid0";
    exp_ov = (sb[k].size() != 0);
    exp_ir = (k == 1) ? (sb[k].size() < 2) : (sb[k].size() == 0 || ordy);
    check({pfx, "_occupancy"}, 32'(occ), 32'(sb[k].size()));
    check({pfx, "_out_valid"}, 32'(ov), 32'(exp_ov));
    check({pfx, "_in_ready"}, 32'(ir), 32'(exp_ir));
    check({pfx, "_out_data"}, 32'(dout), exp_ov ? 32'(sb[k][0]) : 32'(last[k]));
    if (exp_ov && ordy) void'(sb[k].pop_front());
    acc = !fl && iv && exp_ir;
    if (fl) begin
      sb[k].delete();
      last[k] = RV;
    end else if (iv && exp_ir) begin
      sb[k].push_back(din);
    end
    if (sb[k].size() != 0) last[k] = sb[k][0];
  endtask

  task automatic tick();
    #1;
    score(1, iv1, ir1, flush1, or1, ov1, d1, q1, occ1, acc1);
    score(0, iv0, ir0, flush0, or0, ov0, d0, q0, occ0, acc0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      last[k] = RV;
    end
  endtask

  initial begin
    bit done;
    rst = 1'b1;
    {flush1, iv1, or1, flush0, iv0, or0} = '0;
    d1 = '0;
    d0 = '0;
    model_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_out_data", 32'(q1), 32'(RV));
    check("rst_occupancy", 32'(occ1), 32'd0);
    check("rst_in_ready", 32'(ir1), 32'd1);
    check("rst_in_ready0", 32'(ir0), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Streaming at full rate.
    or1 = 1'b1; iv1 = 1'b1;
    d1 = 16'h1111; tick();
    d1 = 16'h2222; tick();
    d1 = 16'h3333; tick();
    iv1 = 1'b0; tick();
    tick();

    // Backpressure fills both slots, then drains in order.
    or1 = 1'b0; iv1 = 1'b1;
    d1 = 16'hAAAA; tick();
    d1 = 16'hBBBB; tick();
    iv1 = 1'b0; tick();
    tick();
    or1 = 1'b1; tick();
    tick();
    tick();

    // Flush while full with a word offered on the input.
    or1 = 1'b0; iv1 = 1'b1;
    d1 = 16'h1234; tick();
    d1 = 16'h5678; tick();
    d1 = 16'hCCCC; flush1 = 1'b1; tick();
    flush1 = 1'b0; iv1 = 1'b0;
    #1;
    check("flush_out_data", 32'(q1), 32'(RV));
    check("flush_occupancy", 32'(occ1), 32'd0);
    @(negedge clk);
    or1 = 1'b1; tick();
    tick();

    // Single-entry mode: stall, then accept while draining in one cycle.
    or0 = 1'b0; iv0 = 1'b1;
    d0 = 16'h5A5A; tick();
    iv0 = 1'b0; tick();
    or0 = 1'b1; iv0 = 1'b1; d0 = 16'hA5A5; tick();
    iv0 = 1'b0; or0 = 1'b0; tick();
    check("single_head", 32'(q0), 32'h0000A5A5);
    or0 = 1'b1; tick();

    // Asynchronous reset mid-cycle with words held.
    or1 = 1'b0; or0 = 1'b0; iv1 = 1'b1; iv0 = 1'b1;
    d1 = 16'h7E7E; d0 = 16'h3C3C; tick();
    iv1 = 1'b0; iv0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(ov1), 32'd0);
    check("async_rst_out_data", 32'(q1), 32'(RV));
    check("async_rst_occupancy", 32'(occ1), 32'd0);
    check("async_rst_in_ready", 32'(ir1), 32'd1);
    check("async_rst_out_data0", 32'(q0), 32'(RV));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Randomised valid/ready, 1000 words into each instance.
    sent[0] = 0;
    sent[1] = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      iv1 = (sent[1] < 1000) && ($urandom_range(0, 3) != 0);
      iv0 = (sent[0] < 1000) && ($urandom_range(0, 3) != 0);
      d1  = W'($urandom);
      d0  = W'($urandom);
      or1 = ($urandom_range(0, 3) != 0);
      or0 = ($urandom_range(0, 3) != 0);
      tick();
      if (acc1) sent[1]++;
      if (acc0) sent[0]++;
      done = (sent[0] == 1000) && (sent[1] == 1000) &&
             (sb[0].size() == 0) && (sb[1].size() == 0);
    end
    check("random_completed", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
